// File: rtl/hs_reg_pipe_pkg.sv
// Shared helpers for the handshaked register pipe.
// clog2 sizes the occupancy counter so it can hold 0..DEPTH.
package hs_reg_pipe_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hs_reg_stage.sv
// One valid/ready register stage; ready looks through to the next stage so a full
// chain still streams one word per cycle.
module hs_reg_stage #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_rd,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_rd
);

    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_data;

    assign in_rd    = ~r_vld | out_rd;
    assign out_vld  = r_vld;
    assign out_data = r_data;

    // Flush only clears valid; bubbles never overwrite the held data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= INIT_VAL;
        end else if (flush) begin
            r_vld  <= 1'b0;
        end else if (in_rd) begin
            r_vld <= in_vld;
            if (in_vld) begin
                r_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/hs_reg_pipe.sv
// DEPTH-stage valid/ready register pipe with flush and a registered occupancy count.
// Latency is DEPTH cycles; full throughput under continuous dout_rd.
module hs_reg_pipe
    import hs_reg_pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    localparam int                   OCC_W      = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_vld,
    output logic                  din_rd,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_vld,
    input  logic                  dout_rd,
    input  logic                  flush,
    output logic [OCC_W-1:0]      occupancy
);

    // Index i is the input side of stage i; index DEPTH is the pipe output.
    logic [DEPTH:0]                 w_vld;
    logic [DEPTH:0]                 w_rd;
    logic [DEPTH:0][DATA_WIDTH-1:0] w_data;
    logic                           w_in_xfer;
    logic                           w_out_xfer;
    logic [OCC_W-1:0]               r_occ;

    assign w_vld[0]  = din_vld;
    assign w_data[0] = din_data;
    assign w_rd[DEPTH] = dout_rd;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        hs_reg_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .INIT_VAL   (INIT_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_vld   (w_vld[i]),
            .in_data  (w_data[i]),
            .in_rd    (w_rd[i]),
            .out_vld  (w_vld[i+1]),
            .out_data (w_data[i+1]),
            .out_rd   (w_rd[i+1])
        );
    end

    assign din_rd    = w_rd[0] & ~flush;
    assign dout_vld  = w_vld[DEPTH];
    assign dout_data = w_data[DEPTH];

    assign w_in_xfer  = din_vld & din_rd;
    assign w_out_xfer = dout_vld & dout_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    assign occupancy = r_occ;

endmodule

// File: tb/tb_hs_reg_pipe.sv
// Bench for hs_reg_pipe (DEPTH=3, 8-bit, INIT_VAL=A5) against a queue-based model
// where the oldest word becomes visible DEPTH cycles after its acceptance.
module tb_hs_reg_pipe;

    localparam int   DW    = 8;
    localparam int   DEPTH = 3;
    localparam logic [DW-1:0] INIT = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din_data;
    logic          din_vld;
    logic          din_rd;
    logic [DW-1:0] dout_data;
    logic          dout_vld;
    logic          dout_rd;
    logic          flush;
    logic [1:0]    occupancy;

    hs_reg_pipe #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .INIT_VAL   (INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_data  (din_data),
        .din_vld   (din_vld),
        .din_rd    (din_rd),
        .dout_data (dout_data),
        .dout_vld  (dout_vld),
        .dout_rd   (dout_rd),
        .flush     (flush),
        .occupancy (occupancy)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: words held by the pipe, oldest first, with acceptance cycle
    logic [DW-1:0] exp_q[$];
    int            t_q[$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        t_q.delete();
    endtask

    // driver: apply inputs for one cycle starting at a negedge, check outputs, advance
    task automatic step(input logic vld, input logic [DW-1:0] d, input logic ordy,
                        input logic fl, output logic acc);
        logic m_vld, m_rd, out_x;
        din_vld  = vld;
        din_data = d;
        dout_rd  = ordy;
        flush    = fl;
        #1;
        m_vld = (exp_q.size() > 0) && (cyc >= t_q[0] + DEPTH);
        m_rd  = !fl && ((exp_q.size() < DEPTH) || ordy);
        check("din_rd", 32'(din_rd), 32'(m_rd));
        check("dout_vld", 32'(dout_vld), 32'(m_vld));
        if (m_vld) check("dout_data", 32'(dout_data), 32'(exp_q[0]));
        check("occupancy", 32'(occupancy), 32'(exp_q.size()));
        acc   = vld && m_rd;
        out_x = m_vld && ordy;
        @(posedge clk);
        cyc++;
        if (fl) begin
            model_clear();
        end else begin
            if (out_x) begin
                void'(exp_q.pop_front());
                void'(t_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(d);
                t_q.push_back(cyc - 1);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0, a);
    endtask

    initial begin
        logic acc;
        int   nxt, budget;

        rst = 1'b1; din_vld = 1'b0; din_data = '0; dout_rd = 1'b0; flush = 1'b0;
        #1;
        check("rst_dout_vld", 32'(dout_vld), 32'd0);
        check("rst_dout_data", 32'(dout_data), 32'(INIT));
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_din_rd", 32'(din_rd), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // latency: 0x11 accepted at t0 shows up at t0+DEPTH
        step(1'b1, 8'h11, 1'b1, 1'b0, acc);
        check("lat_acc", 32'(acc), 32'd1);
        idle(2, 1'b1);
        #1;
        check("lat_vld", 32'(dout_vld), 32'd1);
        check("lat_data", 32'(dout_data), 32'h11);
        idle(2, 1'b1);

        // streaming 0x01..0x10
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b1, 1'b0, acc);
        idle(4, 1'b1);

        // backpressure: only DEPTH of 5 words fit
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0, acc);
            check("bp_acc", 32'(acc), (i <= DEPTH) ? 32'd1 : 32'd0);
        end
        check("bp_occ", 32'(occupancy), 32'd3);
        idle(2, 1'b0);
        nxt = 4; budget = 20;
        while (nxt <= 5 && budget > 0) begin
            step(1'b1, DW'(nxt), 1'b1, 1'b0, acc);
            if (acc) nxt++;
            budget--;
        end
        check("bp_retry_done", 32'(nxt), 32'd6);
        idle(5, 1'b1);

        // simultaneous in/out while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, acc);
        step(1'b1, 8'h4F, 1'b1, 1'b0, acc);
        check("full_pass_acc", 32'(acc), 32'd1);
        check("full_pass_occ", 32'(occupancy), 32'd3);
        idle(6, 1'b1);

        // flush with 2 words held
        step(1'b1, 8'h21, 1'b0, 1'b0, acc);
        step(1'b1, 8'h22, 1'b0, 1'b0, acc);
        step(1'b1, 8'h23, 1'b0, 1'b1, acc);
        check("flush_no_acc", 32'(acc), 32'd0);
        #1;
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_vld", 32'(dout_vld), 32'd0);
        step(1'b1, 8'h24, 1'b1, 1'b0, acc);
        idle(DEPTH + 1, 1'b1);

        // reset mid-transfer, asserted mid-cycle
        step(1'b1, 8'h31, 1'b0, 1'b0, acc);
        step(1'b1, 8'h32, 1'b0, 1'b0, acc);
        #2;
        rst = 1'b1;
        din_vld = 1'b0;
        #1;
        check("mid_rst_vld", 32'(dout_vld), 32'd0);
        check("mid_rst_data", 32'(dout_data), 32'(INIT));
        check("mid_rst_occ", 32'(occupancy), 32'd0);
        check("mid_rst_din_rd", 32'(din_rd), 32'd1);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h33, 1'b1, 1'b0, acc);
        check("post_rst_acc", 32'(acc), 32'd1);
        idle(DEPTH + 1, 1'b1);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 199) == 0, acc);
        end
        idle(DEPTH + 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hs_reg_pipe.md
Name: hs_reg_pipe

Overview:
- Parametrised successor to the single-bit D flip-flop: a chain of DEPTH valid/ready handshaked register stages carrying DATA_WIDTH-bit words.
- Full throughput (one word per cycle) with backpressure, programmable reset value, synchronous flush and an occupancy count.
- Used wherever a bus needs registering for timing or a fixed latency without losing the handshake.

Parameters:
- DATA_WIDTH, 8, width of the data word; must be >= 1.
- DEPTH, 2, number of register stages, which equals the latency; must be >= 1.
- INIT_VAL, 0, value loaded into every stage data register on reset; width DATA_WIDTH.
- OCC_W, clog2(DEPTH+1), width of the occupancy output; derived, not overridden.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- din_data  in  DATA_WIDTH  input word.
- din_vld  in  1  input word valid.
- din_rd  out  1  pipe can accept a word this cycle.
- dout_data  out  DATA_WIDTH  output word, taken from the last stage.
- dout_vld  out  1  last stage holds a valid word.
- dout_rd  in  1  consumer accepts a word this cycle.
- flush  in  1  synchronous: discard all held words.
- occupancy  out  OCC_W  number of valid words held, 0..DEPTH.

Behaviour:
- Interface rule: one clock, clk. Reset rst is asynchronous and active-high.
- Stage state: vld[i] and data[i] for i = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives dout.
- Reset (asynchronous, takes effect immediately):
  - all vld[i] = 0, all data[i] = INIT_VAL, occupancy = 0.
  - dout_vld = 0, dout_data = INIT_VAL.
  - din_rd = 1 while rst is asserted (combinational from empty stage 0), but any transfer in that cycle is discarded.
- Transfer rules:
  - Transfer at din when din_vld & din_rd. Transfer at dout when dout_vld & dout_rd.
  - Stage ready: rd[DEPTH-1] = ~vld[DEPTH-1] | dout_rd. For i < DEPTH-1: rd[i] = ~vld[i] | rd[i+1].
  - din_rd = rd[0] & ~flush.
  - Ready propagates combinationally through the chain. No combinational path from din_vld/din_data to dout.
- Stage update each cycle:
  - If rd[i]: vld[i] <= vld-in, data[i] <= data-in, where vld-in/data-in come from stage i-1 (or from din for stage 0).
  - Otherwise the stage holds.
  - data[i] is loaded only when the incoming valid is 1; empty bubbles do not overwrite data.
- Latency: a word accepted in cycle t with dout_rd held at 1 appears with dout_vld = 1 in cycle t+DEPTH.
- Throughput: back-to-back words with dout_rd = 1 give one output per cycle, with no bubbles inserted.
- Backpressure: while dout_rd = 0, the pipe keeps accepting until all DEPTH stages are valid, then din_rd = 0. Bubbles between words are compressed.
- Data stability: while dout_vld = 1 and dout_rd = 0, dout_data must not change.
- Occupancy: registered count of vld bits.
  - +1 on a din transfer, -1 on a dout transfer, unchanged when both occur in the same cycle.
  - Never exceeds DEPTH or drops below 0.
- flush (synchronous, highest priority below rst):
  - Next cycle all vld = 0 and occupancy = 0. Data registers keep their old values.
  - din_rd = 0 during the flush cycle, so no word is accepted.
  - dout_vld may still be 1 in the flush cycle. If dout_rd = 1 that word counts as consumed, but the flush outcome is the same.
- Reset mid-transfer: in-flight words are lost, with no partial output. The pipe accepts again in the first cycle after rst deasserts.
- DEPTH = 1: degenerates to a single handshaked register with din_rd = ~vld | dout_rd.

Decomposition:
- Shared package: the clog2 function used to derive OCC_W.
- Sub-module hs_reg_stage (parameter DATA_WIDTH, INIT_VAL): one stage with in_vld/in_data/in_rd and out_vld/out_data/out_rd.
- hs_reg_pipe instantiates DEPTH copies of hs_reg_stage in a generate loop, plus the occupancy counter and flush gating.

Test Plan:
- Reset and latency, DEPTH=3, DATA_WIDTH=8, INIT_VAL=8'hA5: assert rst mid-cycle -> dout_vld=0, dout_data=8'hA5, occupancy=0 immediately. Release rst, send 8'h11 at t0 with dout_rd=1 -> dout_vld=1, dout_data=8'h11 at t0+3.
- Streaming: words 0x01..0x10 on consecutive cycles, dout_rd=1 -> 16 outputs on consecutive cycles, in order, with occupancy settling at 3.
- Full/backpressure: dout_rd=0, send 5 words -> only 3 accepted, din_rd=0 from the 4th attempt, occupancy=3. Set dout_rd=1 -> words 1..5 emerge in order, with dout_data stable throughout stalls.
- Simultaneous in/out at full (occupancy=3, din_vld=1, dout_rd=1) -> din_rd=1, occupancy stays 3, no word lost or duplicated.
- Flush with 2 words held -> next cycle occupancy=0 and dout_vld=0, din_rd=0 during the flush cycle; the next input word emerges after exactly DEPTH cycles.
- Random din_vld/dout_rd (10k cycles) against a scoreboard FIFO model -> order and content match, and occupancy equals the model count on every cycle.
